// File: rtl/ram_access_master_if.sv
// Request/response handshake between the load/store stage and ram_access_master.
// The pipeline side uses the master modport; the controller uses the slave modport.
interface ram_access_master_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/ram_access_master.sv
// Initiator-side controller for the 4 KB data RAM: range/alignment check, RAM strobes, extended load data.
// Optional macro RAM_MISALIGN_SPLIT_EN turns misaligned half/word accesses into byte sequences (SPLIT state).
module ram_access_master #(
   parameter logic [19:0] BASE_HI      = 20'h00000,
   parameter bit          ERR_ON_SIZE3 = 1'b1
) (
   input  logic                clk,
   input  logic                clr,
   ram_access_master_if.slave  bus,
   output logic                busy,
   output logic [11:0]         ram_addr,
   output logic [31:0]         ram_wdata,
   output logic [1:0]          ram_mode,
   output logic                ram_memwrite,
   output logic                ram_sel,
   output logic                ram_ld,
   input  logic [31:0]         ram_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RESP
`ifdef RAM_MISALIGN_SPLIT_EN
      , SPLIT
`endif
   } state_t;

   state_t      state;
   logic        wr_q;
   logic [1:0]  size_q;
   logic        signed_q;
   logic [11:0] addr_q;
   logic [31:0] wdata_q;
   logic        resp_valid_q;
   logic        resp_err_q;
   logic [31:0] resp_rdata_q;

   logic [1:0]  eff_size;
   logic        range_err;
   logic        size3_err;
   logic        misalign;
   logic        req_err;

   function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sz, input logic sgn);
      case (sz)
         2'b00:   return {{24{sgn & d[7]}}, d[7:0]};
         2'b01:   return {{16{sgn & d[15]}}, d[15:0]};
         default: return d;
      endcase
   endfunction

   // Size 11 behaves as a word whenever it is not rejected outright.
   assign eff_size  = (bus.req_size == 2'b11) ? 2'b10 : bus.req_size;
   assign range_err = (bus.req_addr[31:12] != BASE_HI);
   assign size3_err = ERR_ON_SIZE3 && (bus.req_size == 2'b11);
   assign misalign  = ((eff_size == 2'b01) && bus.req_addr[0]) ||
                      ((eff_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));

`ifdef RAM_MISALIGN_SPLIT_EN
   logic [1:0]  byte_cnt;
   logic [1:0]  last_cnt;
   logic [31:0] split_acc;
   logic [31:0] split_data;
   logic [12:0] last_addr;

   // The carry out of the last byte address flags a sequence running past 0xFFF.
   assign last_addr = {1'b0, bus.req_addr[11:0]} + ((eff_size == 2'b01) ? 13'd1 : 13'd3);
   assign req_err   = range_err | size3_err | (misalign & last_addr[12]);
   assign last_cnt  = (size_q == 2'b01) ? 2'd1 : 2'd3;

   always_comb begin
      split_data = split_acc;
      split_data[{byte_cnt, 3'b000} +: 8] = ram_rdata[7:0];
   end
`else
   assign req_err = range_err | size3_err | misalign;
`endif

   always_ff @(posedge clk) begin
      if (clr) begin
         state        <= IDLE;
         wr_q         <= 1'b0;
         size_q       <= 2'b00;
         signed_q     <= 1'b0;
         addr_q       <= 12'h000;
         wdata_q      <= 32'h0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'h0;
`ifdef RAM_MISALIGN_SPLIT_EN
         byte_cnt     <= 2'd0;
         split_acc    <= 32'h0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  wr_q     <= bus.req_write;
                  size_q   <= eff_size;
                  signed_q <= bus.req_signed;
                  addr_q   <= bus.req_addr[11:0];
                  wdata_q  <= bus.req_wdata;
                  if (req_err) begin
                     state        <= RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= 32'h0;
`ifdef RAM_MISALIGN_SPLIT_EN
                  end else if (misalign) begin
                     state     <= SPLIT;
                     byte_cnt  <= 2'd0;
                     split_acc <= 32'h0;
`endif
                  end else begin
                     state <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               state        <= RESP;
               resp_valid_q <= 1'b1;
               resp_err_q   <= 1'b0;
               resp_rdata_q <= wr_q ? 32'h0 : extend(ram_rdata, size_q, signed_q);
            end
`ifdef RAM_MISALIGN_SPLIT_EN
            SPLIT: begin
               split_acc <= split_data;
               if (byte_cnt == last_cnt) begin
                  state        <= RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b0;
                  resp_rdata_q <= wr_q ? 32'h0 : extend(split_data, size_q, signed_q);
               end else begin
                  byte_cnt <= byte_cnt + 2'd1;
               end
            end
`endif
            RESP: begin
               state        <= IDLE;
               resp_valid_q <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Strobes are gated by clr so a store caught by reset never commits.
   always_comb begin
      ram_addr     = addr_q;
      ram_wdata    = wdata_q;
      ram_mode     = size_q;
      ram_sel      = 1'b0;
      ram_memwrite = 1'b0;
      ram_ld       = 1'b0;
      case (state)
         ISSUE: begin
            ram_sel      = ~clr;
            ram_memwrite = wr_q & ~clr;
            ram_ld       = ~wr_q;
         end
`ifdef RAM_MISALIGN_SPLIT_EN
         SPLIT: begin
            ram_addr     = addr_q + {10'b0, byte_cnt};
            ram_wdata    = {24'h0, wdata_q[{byte_cnt, 3'b000} +: 8]};
            ram_mode     = 2'b00;
            ram_sel      = ~clr;
            ram_memwrite = wr_q & ~clr;
            ram_ld       = ~wr_q;
         end
`endif
         default: ;
      endcase
   end

   assign busy           = (state != IDLE);
   assign bus.req_ready  = (state == IDLE);
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_ram_access_master.sv
// Directed bench for ram_access_master with a byte-array RAM model behind the RAM port.
module tb_ram_access_master;

   logic        clk = 1'b0;
   logic        clr;
   logic        busy;
   logic [11:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [1:0]  ram_mode;
   logic        ram_memwrite;
   logic        ram_sel;
   logic        ram_ld;
   logic [31:0] ram_rdata;

   ram_access_master_if bus ();

   ram_access_master dut (
      .clk          (clk),
      .clr          (clr),
      .bus          (bus),
      .busy         (busy),
      .ram_addr     (ram_addr),
      .ram_wdata    (ram_wdata),
      .ram_mode     (ram_mode),
      .ram_memwrite (ram_memwrite),
      .ram_sel      (ram_sel),
      .ram_ld       (ram_ld),
      .ram_rdata    (ram_rdata)
   );

   always #5 clk = ~clk;

   // Little-endian byte RAM; reads are combinational and zero-extended.
   logic [7:0] mem [0:4095];

   always @(posedge clk) begin
      if (ram_sel && ram_memwrite) begin
         case (ram_mode)
            2'b00: mem[ram_addr] <= ram_wdata[7:0];
            2'b01: begin
               mem[ram_addr]         <= ram_wdata[7:0];
               mem[ram_addr + 12'd1] <= ram_wdata[15:8];
            end
            default: begin
               mem[ram_addr]         <= ram_wdata[7:0];
               mem[ram_addr + 12'd1] <= ram_wdata[15:8];
               mem[ram_addr + 12'd2] <= ram_wdata[23:16];
               mem[ram_addr + 12'd3] <= ram_wdata[31:24];
            end
         endcase
      end
   end

   always_comb begin
      case (ram_mode)
         2'b00:   ram_rdata = {24'h0, mem[ram_addr]};
         2'b01:   ram_rdata = {16'h0, mem[ram_addr + 12'd1], mem[ram_addr]};
         default: ram_rdata = {mem[ram_addr + 12'd3], mem[ram_addr + 12'd2],
                               mem[ram_addr + 12'd1], mem[ram_addr]};
      endcase
   end

   int          checks = 0;
   int          passes = 0;
   int          lat;
   logic        sel_seen;
   logic [1:0]  mode_seen;
   logic [11:0] addr_seen;
   logic [31:0] got_rdata;
   logic        got_err;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) passes++;
      else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
   endtask

   // Issues one request, then watches up to 10 cycles for the response.
   task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_write  = wr;
      bus.req_size   = size;
      bus.req_signed = sgn;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      lat       = 0;
      sel_seen  = 1'b0;
      mode_seen = 2'bxx;
      addr_seen = 12'hxxx;
      got_rdata = 32'hxxxxxxxx;
      got_err   = 1'bx;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (ram_sel && !sel_seen) begin
            sel_seen  = 1'b1;
            mode_seen = ram_mode;
            addr_seen = ram_addr;
         end
         if (bus.resp_valid) begin
            lat       = i;
            got_rdata = bus.resp_rdata;
            got_err   = bus.resp_err;
            break;
         end
      end
   endtask

   task automatic expectResp(input string tag, input int exp_lat, input logic exp_err,
                             input logic [31:0] exp_rdata, input logic exp_sel);
      checkOutput({tag, " latency"}, lat, exp_lat);
      checkOutput({tag, " err"}, got_err, exp_err);
      checkOutput({tag, " rdata"}, got_rdata, exp_rdata);
      checkOutput({tag, " sel"}, sel_seen, exp_sel);
   endtask

   initial begin
      clr            = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_size   = 2'b00;
      bus.req_signed = 1'b0;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      repeat (2) @(posedge clk);
      #1 clr = 1'b0;
      @(negedge clk);
      checkOutput("reset resp_valid", bus.resp_valid, 1'b0);
      checkOutput("reset resp_err", bus.resp_err, 1'b0);
      checkOutput("reset resp_rdata", bus.resp_rdata, 32'h0);
      checkOutput("reset req_ready", bus.req_ready, 1'b1);
      checkOutput("reset busy", busy, 1'b0);
      checkOutput("reset ram_sel", ram_sel, 1'b0);

      applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEADBEEF);
      expectResp("store word 010", 2, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
      expectResp("load word 010", 2, 1'b0, 32'hDEADBEEF, 1'b1);
      @(negedge clk);
      checkOutput("hold resp_valid", bus.resp_valid, 1'b0);
      checkOutput("hold resp_rdata", bus.resp_rdata, 32'hDEADBEEF);

      applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0014, 32'h55667788);
      expectResp("store word 014", 2, 1'b0, 32'h0, 1'b1);

      applyStimulus(1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_0080);
      expectResp("store byte 013", 2, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0);
      expectResp("load sbyte 013", 2, 1'b0, 32'hFFFFFF80, 1'b1);
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0);
      expectResp("load ubyte 013", 2, 1'b0, 32'h00000080, 1'b1);

      applyStimulus(1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h0000_8001);
      expectResp("store half 022", 2, 1'b0, 32'h0, 1'b1);
      checkOutput("store half mode", mode_seen, 2'b01);
      checkOutput("store half addr", addr_seen, 12'h022);
      applyStimulus(1'b0, 2'b01, 1'b1, 32'h0000_0022, 32'h0);
      expectResp("load shalf 022", 2, 1'b0, 32'hFFFF8001, 1'b1);
      applyStimulus(1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'h0);
      expectResp("load uhalf 022", 2, 1'b0, 32'h00008001, 1'b1);

      applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0FFC, 32'hCAFEF00D);
      expectResp("store word FFC", 2, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0FFC, 32'h0);
      expectResp("load word FFC", 2, 1'b0, 32'hCAFEF00D, 1'b1);

      applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0);
      expectResp("load word 1000", 1, 1'b1, 32'h0, 1'b0);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'h0);
      expectResp("load word 80000010", 1, 1'b1, 32'h0, 1'b0);
      applyStimulus(1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0);
      expectResp("load size3", 1, 1'b1, 32'h0, 1'b0);

`ifdef RAM_MISALIGN_SPLIT_EN
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0011, 32'h0);
      expectResp("split load 011", 5, 1'b0, 32'h8880ADBE, 1'b1);
`else
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0011, 32'h0);
      expectResp("misaligned load 011", 1, 1'b1, 32'h0, 1'b0);
      applyStimulus(1'b0, 2'b01, 1'b0, 32'h0000_0023, 32'h0);
      expectResp("misaligned half 023", 1, 1'b1, 32'h0, 1'b0);
`endif

      applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'h11223344);
      expectResp("store word 040", 2, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b1;
      bus.req_size   = 2'b10;
      bus.req_signed = 1'b0;
      bus.req_addr   = 32'h0000_0040;
      bus.req_wdata  = 32'h12345678;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      checkOutput("abort issue sel", ram_sel, 1'b1);
      clr = 1'b1;
      #1 checkOutput("abort gated sel", ram_sel, 1'b0);
      checkOutput("abort gated memwrite", ram_memwrite, 1'b0);
      @(posedge clk);
      #1 clr = 1'b0;
      @(negedge clk);
      checkOutput("abort req_ready", bus.req_ready, 1'b1);
      checkOutput("abort resp_valid 1", bus.resp_valid, 1'b0);
      @(negedge clk);
      checkOutput("abort resp_valid 2", bus.resp_valid, 1'b0);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0);
      expectResp("load after abort", 2, 1'b0, 32'h11223344, 1'b1);

      // A request raised while busy and withdrawn before IDLE must not be taken.
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_size  = 2'b10;
      bus.req_addr  = 32'h0000_0010;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h0000_0014;
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      checkOutput("dropped valid busy 1", busy, 1'b0);
      @(negedge clk);
      checkOutput("dropped valid busy 2", busy, 1'b0);
      checkOutput("dropped valid resp", bus.resp_valid, 1'b0);

`ifdef RAM_MISALIGN_SPLIT_EN
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0041, 32'hA1B2C3D4);
      expectResp("split store 041", 5, 1'b0, 32'h0, 1'b1);
      checkOutput("split store first addr", addr_seen, 12'h041);
      checkOutput("split store mode", mode_seen, 2'b00);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0041, 32'h0);
      expectResp("split load 041", 5, 1'b0, 32'hA1B2C3D4, 1'b1);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0FFE, 32'h0);
      expectResp("split overflow FFE", 1, 1'b1, 32'h0, 1'b0);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0FFD, 32'h0);
      expectResp("split overflow FFD", 1, 1'b1, 32'h0, 1'b0);
`endif

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/ram_access_master.md
Name: ram_access_master

Overview:
- Initiator-side controller for the on-chip 4 KB data RAM. It sits between the pipeline's load/store stage and the RAM port.
- Accepts one load/store request at a time over a valid/ready handshake, range-checks it and checks its alignment.
- Drives the RAM's address, mode, write, select and load strobes, and returns a registered response.
- Load data is sign- or zero-extended to 32 bits in the response.

Parameters:
- BASE_HI, 20'h00000, required value of req_addr[31:12] for a request to fall inside the RAM window.
- ERR_ON_SIZE3, 1, when 1 a request with req_size=2'b11 is an error; when 0 it is treated as word.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 halfword, 10 word.
- req_signed  in  1  sign-extend load data.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  request rejected; valid with resp_valid.
- busy  out  1  state is not IDLE.
- ram_addr  out  12  to RAM Addr.
- ram_wdata  out  32  to RAM data_in.
- ram_mode  out  2  to RAM Mode; same encoding as req_size.
- ram_memwrite  out  1  to RAM memWrite.
- ram_sel  out  1  to RAM sel.
- ram_ld  out  1  to RAM ld.
- ram_rdata  in  32  from RAM data_out. It is combinational and zero-extended: the byte or half sits in the low bits.

Behaviour:
- Reset (clr sampled high):
  - State goes to IDLE; resp_valid=0, resp_err=0, resp_rdata=0.
  - All request registers are cleared.
  - RAM contents are not touched; the block never drives RAM clr.
- State machine: IDLE, ISSUE, RESP.
  - SPLIT is an additional state, present only with the optional feature.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch write, size, signed, addr and wdata.
  - If the error check fails, go to RESP with the error flag set; otherwise go to ISSUE.
- Error check (any one condition raises the error):
  - req_addr[31:12]!=BASE_HI.
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
  - size=11 while ERR_ON_SIZE3=1.
- ISSUE (exactly one cycle):
  - ram_sel=1 and ram_addr=addr[11:0].
  - ram_mode=size; ram_memwrite=write; ram_ld=~write; ram_wdata=wdata.
  - The store commits at the closing edge.
  - For loads, ram_rdata is sampled at the closing edge and extended:
    - byte: bit7 is replicated when signed, zero-filled otherwise.
    - half: bit15 is replicated when signed, zero-filled otherwise.
    - word: passed unchanged.
  - Next state is RESP.
- RESP (one cycle):
  - resp_valid=1 with resp_err and resp_rdata; then go to IDLE.
  - resp_rdata and resp_err hold their values after resp_valid drops, until the next response.
- RAM strobes outside ISSUE/SPLIT: ram_sel, ram_memwrite and ram_ld are all 0.
- Clr gating: ram_sel and ram_memwrite are gated with ~clr combinationally. A store in flight when clr is sampled therefore does not commit.
- Latency:
  - Request accepted at edge N.
  - ISSUE during cycle N+1.
  - resp_valid during cycle N+2.
  - Errors: resp_valid during cycle N+1, with no RAM access.
- Throughput: one request per 3 cycles; req_ready is 0 in ISSUE and RESP.
- Boundaries:
  - addr 0xFFC word: legal.
  - addr 0x1000 with BASE_HI=0: error.
  - A req_valid that drops before acceptance is ignored.

Optional Feature:
- Macro: RAM_MISALIGN_SPLIT_EN.
- Defined: a misaligned halfword or word that passes the range check is not an error. Instead it executes as a sequence of byte accesses.
  - Sequence: 2 bytes for a halfword, 4 for a word, at addr, addr+1, … in little-endian order.
  - State SPLIT replaces ISSUE and runs one cycle per byte, driven by a 2-bit byte counter.
  - Stores send wdata byte k on ram_wdata[7:0]; loads assemble byte k into bits 8k+7:8k, then extend as above.
  - A sequence whose last byte address exceeds 0xFFF is an error, detected at acceptance; no byte is written.
  - Latency is N+1+nbytes for resp_valid.
  - A clr during SPLIT aborts the sequence. Bytes already written stay written.
- Undefined: misalignment is an error and the SPLIT state is absent.

Test Plan:
- Aligned word store, then load: store 0xDEADBEEF to 0x010, then load word from 0x010 → resp_rdata=0xDEADBEEF, resp_err=0; resp_valid exactly 2 cycles after acceptance.
- Byte extension: store byte 0x80 to 0x013, then load byte from 0x013 with signed=1 → 0xFFFFFF80; same load with signed=0 → 0x00000080.
- Halfword extension: store half 0x8001 to 0x022, then load signed half → 0xFFFF8001; ram_mode=01 and ram_addr=0x022 during ISSUE.
- Errors: word load at 0x011, and word load at 0x00001000 → resp_err=1, resp_rdata=0, ram_sel never asserted, resp_valid 1 cycle after acceptance.
- Reset mid-store: clr asserted during the ISSUE cycle of a store of 0x12345678 to 0x040 → the word at 0x040 keeps its old value; resp_valid never pulses; req_ready=1 the cycle after.
- With RAM_MISALIGN_SPLIT_EN: store word 0xA1B2C3D4 to 0x041, then load word from 0x041 → 0xA1B2C3D4 after 4 byte cycles; word load at 0xFFE → resp_err=1.
